// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers bursty producer samples in a small FIFO and
// releases them to fir_system as single-cycle pulses spaced at least GAP
// cycles apart, so each sample completes downstream before the next arrives.
module fir_sample_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int GAP        = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic                   enable,
   input  logic                   flush,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   data_out_valid,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(GAP) + 1;
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   // The pulse edge counts as the first of the GAP edges, so WAIT spans GAP-1 edges.
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           gap_q, gap_d;
   logic [AW-1:0]           rptr_q, wptr_q;
   logic [AW:0]             count_q, count_d;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    push;
   logic                    issue;

   // s_ready is registered from next occupancy, so a full FIFO refuses a push
   // even on an edge that also pops.
   assign push  = s_valid & s_ready;
   assign issue = (state_q == ST_IDLE) & enable & (count_q != '0);
   assign level = count_q;

   // Pacer state and gap counter register; flush returns the pacer to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   // Pacer next-state: leave IDLE on an issue, leave WAIT when the gap expires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (issue) state_d = ST_WAIT;
         ST_WAIT: if (gap_q == CW'(1)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pacer output logic: load the gap counter on an issue, count it down in WAIT.
   always_comb begin
      gap_d = gap_q;
      if (issue)
         gap_d = GAP_LOAD;
      else if (state_q == ST_WAIT)
         gap_d = gap_q - CW'(1);
   end

   // FIFO next occupancy from the push/pop pair seen at this edge.
   always_comb begin
      count_d = count_q;
      case ({push, issue})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers, occupancy and registered ready; flush discards this edge's push and pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         s_ready <= 1'b0;
      end else if (flush) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         s_ready <= 1'b1;
      end else begin
         if (push)  wptr_q <= wptr_q + AW'(1);
         if (issue) rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
         s_ready <= (count_d < FULL_LVL);
      end
   end

   // FIFO storage; sample data needs no reset.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wptr_q] <= s_data;
   end

   // Registered pacer outputs; data_out holds the last issued sample between pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else if (flush) begin
         data_out_valid <= 1'b0;
      end else begin
         data_out_valid <= issue;
         if (issue)
            data_out <= mem[rptr_q];
      end
   end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: directed steps with random sample data,
// compared every cycle against a queue-based reference model.
module tb_fir_sample_feeder;
   localparam int DATA_WIDTH = 16;
   localparam int DEPTH      = 8;
   localparam int GAP        = 12;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [DATA_WIDTH-1:0]   s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic                    enable;
   logic                    flush;
   logic [DATA_WIDTH-1:0]   data_out;
   logic                    data_out_valid;
   logic [$clog2(DEPTH):0]  level;

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;

   // Reference model state: contents as a queue, earliest cycle of next allowed pulse.
   logic [DATA_WIDTH-1:0] fifo_m[$];
   int                    next_ok;
   bit                    ready_m;
   bit                    valid_m;
   logic [DATA_WIDTH-1:0] out_m;

   // Logs of observed pulses and of accepted samples, cleared per test.
   logic [DATA_WIDTH-1:0] pulse_data[$];
   int                    pulse_cyc[$];
   logic [DATA_WIDTH-1:0] acc_log[$];

   fir_sample_feeder #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .GAP       (GAP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .enable        (enable),
      .flush         (flush),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .level         (level)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fifo_m.delete();
      next_ok = 0;
      ready_m = 1'b0;
      valid_m = 1'b0;
      out_m   = '0;
   endtask

   // One clock edge of the reference: pop head if paced and enabled, append if accepted.
   task automatic model_edge();
      bit do_issue;
      bit do_push;
      if (!rst) begin
         model_reset();
      end else if (flush) begin
         fifo_m.delete();
         valid_m = 1'b0;
         ready_m = 1'b1;
         next_ok = 0;
      end else begin
         do_issue = enable && (fifo_m.size() != 0) && (cycle >= next_ok);
         do_push  = s_valid && ready_m;
         if (do_issue) begin
            out_m   = fifo_m.pop_front();
            next_ok = cycle + GAP;
         end
         valid_m = do_issue;
         if (do_push) begin
            fifo_m.push_back(s_data);
            acc_log.push_back(s_data);
         end
         ready_m = (fifo_m.size() < DEPTH);
      end
   endtask

   task automatic check_all();
      chk("data_out_valid", 32'(data_out_valid), 32'(valid_m));
      chk("data_out", 32'(data_out), 32'(out_m));
      chk("s_ready", 32'(s_ready), 32'(ready_m));
      chk("level", 32'(level), 32'(fifo_m.size()));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (data_out_valid === 1'b1) begin
         pulse_data.push_back(data_out);
         pulse_cyc.push_back(cycle);
      end
      cycle++;
   endtask

   task automatic clear_logs();
      pulse_data.delete();
      pulse_cyc.delete();
      acc_log.delete();
   endtask

   // Hold s_valid with the word until the DUT takes it, within a cycle budget.
   task automatic push_word(input logic [DATA_WIDTH-1:0] v);
      bit ok;
      ok      = 1'b0;
      s_data  = v;
      s_valid = 1'b1;
      for (int k = 0; k < 64 && !ok; k++) begin
         ok = (s_ready === 1'b1);
         step();
      end
      s_valid = 1'b0;
      chk("push_accept", 32'(ok), 32'd1);
   endtask

   task automatic check_order(input string tag, input int n);
      chk({tag, "_count"}, 32'(pulse_data.size()), 32'(n));
      for (int i = 0; i < n && i < pulse_data.size() && i < acc_log.size(); i++)
         chk({tag, "_order"}, 32'(pulse_data[i]), 32'(acc_log[i]));
   endtask

   initial begin
      int n_before;
      rst     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      enable  = 1'b0;
      flush   = 1'b0;
      model_reset();
      #12;
      check_all();
      chk("reset_s_ready", 32'(s_ready), 32'd0);
      rst = 1'b1;
      step();
      chk("s_ready_first_edge", 32'(s_ready), 32'd1);

      // Test 1: single-sample latency
      clear_logs();
      enable  = 1'b1;
      s_data  = 16'h0001;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      step();
      chk("t1_valid", 32'(data_out_valid), 32'd1);
      chk("t1_data", 32'(data_out), 32'h0001);
      chk("t1_level", 32'(level), 32'd0);
      step();
      chk("t1_pulse_end", 32'(data_out_valid), 32'd0);
      chk("t1_hold", 32'(data_out), 32'h0001);
      repeat (GAP) step();

      // Test 2: burst of 8, pulses exactly GAP apart and in order
      clear_logs();
      for (int i = 0; i < 8; i++) push_word(16'(16'h0010 + i));
      repeat (8 * GAP) step();
      chk("t2_count", 32'(pulse_data.size()), 32'd8);
      for (int i = 0; i < 8 && i < pulse_data.size(); i++) begin
         chk("t2_data", 32'(pulse_data[i]), 32'(16'h0010 + i));
         if (i > 0) chk("t2_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(GAP));
      end

      // Test 3: fill with enable low, then release
      clear_logs();
      enable  = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         s_data = 16'($urandom);
         step();
      end
      s_valid = 1'b0;
      chk("t3_level_full", 32'(level), 32'(DEPTH));
      chk("t3_ready_full", 32'(s_ready), 32'd0);
      chk("t3_no_pulse", 32'(pulse_data.size()), 32'd0);
      enable = 1'b1;
      step();
      chk("t3_first_pulse", 32'(data_out_valid), 32'd1);
      chk("t3_ready_back", 32'(s_ready), 32'd1);
      repeat (8 * GAP + 4) step();
      check_order("t3", 8);

      // Test 4: flush during WAIT
      clear_logs();
      for (int i = 0; i < 3; i++) push_word(16'($urandom));
      repeat (3) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t4_level", 32'(level), 32'd0);
      chk("t4_ready", 32'(s_ready), 32'd1);
      n_before = pulse_data.size();
      repeat (2 * GAP) step();
      chk("t4_no_pulse", 32'(pulse_data.size()), 32'(n_before));
      push_word(16'hBEEF);
      repeat (GAP) step();
      chk("t4_one_pulse", 32'(pulse_data.size()), 32'(n_before + 1));
      if (pulse_data.size() > n_before)
         chk("t4_beef", 32'(pulse_data[pulse_data.size()-1]), 32'h0000BEEF);

      // Test 5: push and pop on one edge, then pointer wrap over 20 samples
      clear_logs();
      enable = 1'b0;
      for (int i = 0; i < 4; i++) push_word(16'($urandom));
      chk("t5_level4", 32'(level), 32'd4);
      enable  = 1'b1;
      s_data  = 16'($urandom);
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      chk("t5_same_level", 32'(level), 32'd4);
      chk("t5_pulse", 32'(data_out_valid), 32'd1);
      for (int i = 0; i < 15; i++) push_word(16'($urandom));
      repeat (10 * GAP) step();
      check_order("t5", 20);

      // Test 6: asynchronous reset in the middle of WAIT
      clear_logs();
      push_word(16'($urandom));
      push_word(16'($urandom));
      repeat (4) step();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("t6_data_out", 32'(data_out), 32'd0);
      chk("t6_valid", 32'(data_out_valid), 32'd0);
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_ready_low", 32'(s_ready), 32'd0);
      #2;
      rst = 1'b1;
      step();
      chk("t6_ready_first_edge", 32'(s_ready), 32'd1);
      n_before = pulse_data.size();
      repeat (2 * GAP) step();
      chk("t6_no_glitch", 32'(pulse_data.size()), 32'(n_before));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
